sbox_stream_decryptor: RTL

// - Receive side of the S-box keystream cipher: accepts framed ciphertext, strips the header and decrypts the payload.
// - Frame format: [seed][len][len x ciphertext bytes].
// - Regenerates the sender keystream: payload byte i is XORed with aes_sbox(seed+i mod 256).
// - Buffers plaintext in a FIFO and delivers it on a valid/ready stream with end-of-frame marking.

---
 rtl/sbox_stream_decryptor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sbox_stream_decryptor.sv
// ============================================================================
// Module   : sbox_stream_decryptor (+ aes_sbox)
// Brief    : Strips [seed][len] headers, XORs the payload with aes_sbox(seed+i)
//            and streams the plaintext out of a FWFT FIFO with end-of-frame marking.
//            Optional macro SBOX_RX_STATS_EN adds frame_cnt / err_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);
  // Entry 0 sits in the most significant byte, so bit-inverting the address selects it.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign data = c_SBOX[{~addr, 3'b000} +: 8];
endmodule

module sbox_stream_decryptor #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       err,
  output logic       busy
`ifdef SBOX_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_S_SEED = 2'd0;
  localparam logic [1:0] c_S_LEN  = 2'd1;
  localparam logic [1:0] c_S_DATA = 2'd2;

  logic [1:0]      r_state, w_state_nxt;
  logic [7:0]      r_index, r_remaining;
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]   r_count, w_count_nxt;
  logic            r_full, r_err;
  logic [8:0]      r_mem [FIFO_DEPTH];

  logic       w_accept, w_push, w_pop, w_last, w_len_zero;
  logic [7:0] w_keystream;

  aes_sbox u_sbox (
    .addr (r_index),
    .data (w_keystream)
  );

  assign w_accept   = s_valid & s_ready;
  assign w_push     = w_accept & (r_state == c_S_DATA);
  assign w_pop      = m_valid & m_ready;
  assign w_last     = (r_remaining == 8'd1);
  assign w_len_zero = w_accept & (r_state == c_S_LEN) & (s_data == 8'h00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= c_S_SEED;
    else if (flush) r_state <= c_S_SEED;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_SEED: if (w_accept) w_state_nxt = c_S_LEN;
      c_S_LEN:  if (w_accept) w_state_nxt = (s_data == 8'h00) ? c_S_SEED : c_S_DATA;
      c_S_DATA: if (w_accept && w_last) w_state_nxt = c_S_SEED;
      default:  w_state_nxt = c_S_SEED;
    endcase
  end

  // Output logic; flush blocks acceptance so the aborted byte is never consumed
  always_comb begin
    s_ready = 1'b0;
    if (!flush) s_ready = (r_state != c_S_DATA) || !r_full;
    busy = (r_state != c_S_SEED) || (r_count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index     <= 8'h00;
      r_remaining <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_len_zero & ~flush;
      if (!flush && w_accept) begin
        case (r_state)
          c_S_SEED: r_index <= s_data;
          c_S_LEN:  r_remaining <= s_data;
          c_S_DATA: begin
            r_index     <= r_index + 8'd1;
            r_remaining <= r_remaining - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (flush) w_count_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_last, s_data ^ w_keystream};
  end

  // Outputs read as zero when the FIFO is empty so they match the reset values
  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
  assign m_last  = m_valid & r_mem[r_rd_ptr][8];
  assign err     = r_err;

`ifdef SBOX_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'h0000;
      err_cnt   <= 8'h00;
    end else begin
      if (!flush && w_push && w_last) frame_cnt <= frame_cnt + 16'd1;
      if (!flush && w_len_zero && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire
